// File: rtl/decode_pipe.sv
// Pipelined decode stage: field extraction, pending-write scoreboard, flush and SP register.
// Build option SCOREBOARD_BYPASS_EN: a same-cycle writeback clears a source hazard.
module decode_pipe #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter logic [XLEN-1:0] SP_RESET = XLEN'(32'h0000_3000),
   localparam int RW = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic            in_wr,
   input  logic            in_rx_src,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_inst,
   output logic [XLEN-1:0] out_pc,
   output logic [RW-1:0]   out_rd,
   output logic [RW-1:0]   out_rs0,
   output logic [RW-1:0]   out_rs1,
   output logic            out_wr,
   input  logic            wb_en,
   input  logic [RW-1:0]   wb_idx,
   input  logic            sp_we,
   input  logic [XLEN-1:0] sp_in,
   output logic [XLEN-1:0] sp_out,
   output logic            sb_busy
);

   logic [RW-1:0]   in_rx, in_ry, in_rz;
   logic            out_valid_reg, out_wr_reg, sb_busy_reg;
   logic [31:0]     out_inst_reg;
   logic [XLEN-1:0] out_pc_reg, sp_reg;
   logic [RW-1:0]   out_rd_reg, out_rs0_reg, out_rs1_reg;
   // Register 0 is never tracked, so the scoreboard simply has no bit for it.
   logic [NREG-1:1] pend_reg, pend_next, src_hit;
   logic            hz, accept;

   assign in_rx = RW'(in_inst[26:22]);
   assign in_ry = RW'(in_inst[21:17]);
   assign in_rz = RW'(in_inst[16:12]);

   assign hz       = in_valid && (|src_hit);
   assign in_ready = !flush && !hz && (!out_valid_reg || out_ready);
   assign accept   = in_valid && in_ready;

   genvar gi;
   generate
      for (gi = 1; gi < NREG; gi++) begin : g_pend
         logic wb_clr, fl_clr, acc_set, used;
         assign wb_clr  = wb_en && (wb_idx == RW'(gi));
         assign fl_clr  = flush && out_valid_reg && out_wr_reg && (out_rd_reg == RW'(gi));
         assign acc_set = accept && in_wr && (in_rx == RW'(gi));
         // rx counts as a source for WAW as well as for read-modify instructions.
         assign used    = (in_ry == RW'(gi)) || (in_rz == RW'(gi)) ||
                          ((in_rx_src || in_wr) && (in_rx == RW'(gi)));
`ifdef SCOREBOARD_BYPASS_EN
         assign src_hit[gi] = used && pend_reg[gi] && !wb_clr;
`else
         assign src_hit[gi] = used && pend_reg[gi];
`endif
         assign pend_next[gi] = acc_set || (pend_reg[gi] && !wb_clr && !fl_clr);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg    <= '0;
         sb_busy_reg <= 1'b0;
      end else begin
         pend_reg    <= pend_next;
         sb_busy_reg <= |pend_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_inst_reg  <= '0;
         out_pc_reg    <= '0;
         out_rd_reg    <= '0;
         out_rs0_reg   <= '0;
         out_rs1_reg   <= '0;
         out_wr_reg    <= 1'b0;
      end else if (flush) begin
         out_valid_reg <= 1'b0;
      end else if (accept) begin
         out_valid_reg <= 1'b1;
         out_inst_reg  <= in_inst;
         out_pc_reg    <= in_pc;
         out_rd_reg    <= in_rx;
         out_rs0_reg   <= in_ry;
         out_rs1_reg   <= in_rz;
         out_wr_reg    <= in_wr;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sp_reg <= SP_RESET;
      else if (sp_we)
         sp_reg <= sp_in;
   end

   assign out_valid = out_valid_reg;
   assign out_inst  = out_inst_reg;
   assign out_pc    = out_pc_reg;
   assign out_rd    = out_rd_reg;
   assign out_rs0   = out_rs0_reg;
   assign out_rs1   = out_rs1_reg;
   assign out_wr    = out_wr_reg;
   assign sp_out    = sp_reg;
   assign sb_busy   = sb_busy_reg;

endmodule
